alu_unit: RTL and testbench

- 32-bit registered ALU with eight operations selected by a 3-bit opcode.
- Seven operations are single-cycle: AND, OR, XOR, NOR, signed set-less-than, add and subtract.
- Modulo is multi-cycle, using an iterative restoring remainder unit.
- Sits in the datapath as the execute-stage arithmetic block; the result is held in an output register.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_if.sv | 13 +
 rtl/alu_mod_unit.sv | 68 ++++++
 rtl/alu_unit.sv | 104 ++++++++++
 tb/tb_alu_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, modulo FSM encoding and default width for the execute-stage ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mod_state_t;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the issue logic (master) and the ALU (slave).
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       aluOP;
  logic [WIDTH-1:0] O;
  logic             less_than;

  modport master (output a, output b, output aluOP, input  O, input  less_than);
  modport slave  (input  a, input  b, input  aluOP, output O, output less_than);
endinterface

// File: rtl/alu_mod_unit.sv
// Iterative restoring remainder engine: one dividend bit per cycle, MSB first.
module alu_mod_unit #(
  parameter int WIDTH     = 32,
  parameter int MOD_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(MOD_ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MOD_ITERS - 1);

  logic [WIDTH-1:0] dividend_p0;
  logic [WIDTH-1:0] divisor_p0;
  logic [WIDTH-1:0] rem_p1;
  logic [CNT_W-1:0] iter_cnt;

  // Shift the next dividend bit in and subtract the divisor when it fits.
  // A zero divisor always "fits", so the remainder degenerates to the dividend.
  function automatic logic [WIDTH-1:0] rem_step(input logic [WIDTH-1:0] r,
                                                input logic             bit_in,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    trial = {r, bit_in};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d}) return diff[WIDTH-1:0];
    else                    return trial[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      dividend_p0 <= '0;
      divisor_p0  <= '0;
      rem_p1      <= '0;
      iter_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (start) begin
      dividend_p0 <= a;
      divisor_p0  <= b;
      rem_p1      <= '0;
      iter_cnt    <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else if (busy) begin
      // iteration stage: p0 operands -> p1 partial remainder
      rem_p1      <= rem_step(rem_p1, dividend_p0[WIDTH-1], divisor_p0);
      dividend_p0 <= dividend_p0 << 1;
      iter_cnt    <= iter_cnt + 1'b1;
      if (iter_cnt == LAST_ITER) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign rem = rem_p1;

endmodule

// File: rtl/alu_unit.sv
// Registered execute-stage ALU: single-cycle logic/arith ops plus multi-cycle unsigned modulo.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int MOD_ITERS = WIDTH
) (
  input  logic CLK,
  input  logic reset,
  alu_if.slave bus
);

  mod_state_t       state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] o_p1;
  logic             lt_p1;
  logic [WIDTH-1:0] alu_res_p0;
  logic             opnd_chg;
  logic             mod_start;
  logic             mod_busy;
  logic             mod_done;
  logic [WIDTH-1:0] mod_rem;

  function automatic logic slt(input logic signed [WIDTH-1:0] x,
                               input logic signed [WIDTH-1:0] y);
    return x < y;
  endfunction

  always_comb begin
    alu_res_p0 = '0;
    case (bus.aluOP)
      OP_AND:  alu_res_p0 = bus.a & bus.b;
      OP_OR:   alu_res_p0 = bus.a | bus.b;
      OP_XOR:  alu_res_p0 = bus.a ^ bus.b;
      OP_NOR:  alu_res_p0 = ~(bus.a | bus.b);
      OP_SLT:  alu_res_p0 = {{(WIDTH-1){1'b0}}, slt(bus.a, bus.b)};
      OP_ADD:  alu_res_p0 = bus.a + bus.b;
      OP_SUB:  alu_res_p0 = bus.a - bus.b;
      default: alu_res_p0 = o_p1;
    endcase
  end

  assign opnd_chg  = (bus.a != a_lat) || (bus.b != b_lat);
  assign mod_start = (state == IDLE) && (bus.aluOP == OP_MOD);

  alu_mod_unit #(
    .WIDTH     (WIDTH),
    .MOD_ITERS (MOD_ITERS)
  ) u_mod (
    .clk   (CLK),
    .reset (reset),
    .start (mod_start),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (mod_busy),
    .done  (mod_done),
    .rem   (mod_rem)
  );

  // result stage: p0 combinational result / engine remainder -> p1 output register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
      a_lat <= '0;
      b_lat <= '0;
      o_p1  <= '0;
      lt_p1 <= 1'b0;
    end else begin
      lt_p1 <= slt(bus.a, bus.b);
      if (bus.aluOP != OP_MOD) begin
        o_p1  <= alu_res_p0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            a_lat <= bus.a;
            b_lat <= bus.b;
            state <= RUN;
          end
          RUN: begin
            // Operand change restarts from IDLE; O keeps its old value meanwhile.
            if (opnd_chg) begin
              state <= IDLE;
            end else if (mod_done) begin
              o_p1  <= mod_rem;
              state <= DONE;
            end else if (!mod_busy) begin
              state <= IDLE;
            end
          end
          DONE: begin
            if (opnd_chg) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.O         = o_p1;
  assign bus.less_than = lt_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed corner cases plus randomized ops vs a behavioural model.
module tb_alu_unit;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  alu_if #(.WIDTH(W)) bus ();

  alu_unit #(.WIDTH(W), .MOD_ITERS(W)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd5: return x + y;
      3'd6: return x - y;
      default: return (y == 32'd0) ? x : (x % y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.aluOP = op;
    bus.a     = x;
    bus.b     = y;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    drive(op, x, y);
    tick();
    chk(tag, bus.O, ref_alu(op, x, y));
    chk({tag, "_lt"}, {31'b0, bus.less_than}, ref_alu(3'd4, x, y));
  endtask

  // O must hold its entry value for lat-1 edges, then show exp on edge lat.
  task automatic mod_wait(input string tag, input logic [31:0] exp, input int lat);
    logic [31:0] hold;
    hold = bus.O;
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_hold"}, bus.O, hold);
    end
    tick();
    chk(tag, bus.O, exp);
  endtask

  task automatic mod_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    drive(3'd7, x, y);
    mod_wait(tag, ref_alu(3'd7, x, y), W + 2);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    drive(3'd0, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_O", bus.O, 32'd0);
    chk("rst_lt", {31'b0, bus.less_than}, 32'd0);

    drive(3'd7, 32'd23, 32'd5);
    rst_n = 1'b1;
    mod_wait("mod_23_5", 32'd3, W + 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mod_done_hold", bus.O, 32'd3);
    end

    do_op("and", 3'd0, 32'd7, 32'd2);
    do_op("or", 3'd1, 32'h0600_0007, 32'd2);
    do_op("xor", 3'd2, 32'h7000_C007, 32'h2000_0002);
    do_op("nor", 3'd3, 32'h7C00_0007, 32'h6000_0002);
    do_op("slt_pos", 3'd4, 32'd1, 32'd6);
    do_op("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'd1);
    do_op("slt_ge", 3'd4, 32'd6, 32'd1);
    do_op("add", 3'd5, 32'd15, 32'd2);
    do_op("add_wrap", 3'd5, 32'hFFFF_FFFF, 32'd1);
    do_op("sub", 3'd6, 32'd23, 32'd2);
    do_op("sub_wrap", 3'd6, 32'd0, 32'd1);
    chk("sub_wrap_abs", bus.O, 32'hFFFF_FFFF);

    do_op("pre_mod0", 3'd0, 32'd5, 32'd4);
    mod_op("mod_b0", 32'd9, 32'd0);

    // Restart: change divisor mid-run, fresh run must yield 100 mod 9 and never 100 mod 7.
    do_op("pre_restart", 3'd1, 32'hA5A5_0000, 32'h0000_5A5A);
    drive(3'd7, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("restart_run_hold", bus.O, 32'hA5A5_5A5A);
    end
    bus.b = 32'd9;
    mod_wait("mod_restart", 32'd1, W + 3);

    // Reset mid-run clears O; a new run then starts straight from IDLE.
    do_op("pre_rst", 3'd5, 32'd40, 32'd2);
    drive(3'd7, 32'd1000, 32'd13);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_O", bus.O, 32'd0);
    rst_n = 1'b1;
    mod_wait("mod_after_rst", 32'd1000 % 32'd13, W + 2);

    for (int n = 0; n < 160; n++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'($urandom_range(0, 15));
        1:       y = x;
        default: y = $urandom;
      endcase
      if (op == 3'd7) begin
        do_op("rnd_pre", 3'd0, x, y);
        mod_op("rnd_mod", x, y);
      end else begin
        do_op("rnd_op", op, x, y);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
